// File: rtl/truth_table_scanner_pkg.sv
// -----------------------------------------------------------------------------
// truth_table_scanner_pkg
// Shared types and constants for the truth-table scanner.
//   SETTLE_W      : width of the settle down-counter (covers 0..255)
//   MAX_INPUTS    : largest supported input count of the characterized block
//   scan_state_t  : scanner FSM states
//   table_width() : number of truth-table bits for a given input count
// -----------------------------------------------------------------------------
package truth_table_scanner_pkg;

  localparam int SETTLE_W   = 8;
  localparam int MAX_INPUTS = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } scan_state_t;

  function automatic int table_width(input int n_inputs);
    return 1 << n_inputs;
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle.sv
// -----------------------------------------------------------------------------
// scan_settle_counter
// Loadable down-counter used to hold each input combination for a programmable
// number of extra cycles. Stops at zero; a load has priority over a decrement.
// Ports:
//   clk        : clock
//   rst_n      : asynchronous active-low reset (count clears to 0)
//   i_load     : load i_load_val on the next edge
//   i_load_val : value to load
//   i_dec      : decrement enable (ignored once the count is zero)
//   o_zero     : count is zero
// -----------------------------------------------------------------------------
module scan_settle_counter
  import truth_table_scanner_pkg::*;
#(
  parameter int WIDTH = SETTLE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;
  logic             w_zero;

  assign w_zero = (r_count == '0);
  assign o_zero = w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && !w_zero) begin
      r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_scanner.sv
// -----------------------------------------------------------------------------
// truth_table_scanner
// Recovers the truth table of an N_INPUTS-input, single-output combinational
// block. Sweeps all input combinations in ascending order on `drive`, holds
// each for SETTLE_CYCLES+1 cycles, captures `sample` in the last held cycle
// and packs the results into `truth_table`. On completion the table is
// compared against `expected`.
//
// state  | meaning
// -------+------------------------------------------------------------------
// S_IDLE | no scan; drive = 0, waiting for start
// S_HOLD | driving combination `index`, counting settle cycles, then capture
// S_DONE | one-cycle completion; done = 1, table_valid/match registered here
//
// Ports:
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start        : one-cycle scan request (ignored while busy)
//   abort        : cancel a scan in progress (wins over start in IDLE)
//   drive        : stimulus; MSB drives inp1, LSB drives inpN
//   sample       : output of the characterized block
//   expected     : reference truth table, sampled in the DONE cycle
//   busy         : scan in progress
//   done         : one-cycle completion pulse
//   table_valid  : truth_table holds a complete result
//   truth_table  : bit i = sample captured while drive == i
//   match        : truth_table == expected (meaningful with table_valid)
// -----------------------------------------------------------------------------
module truth_table_scanner
  import truth_table_scanner_pkg::*;
#(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       abort,
  output logic [N_INPUTS-1:0]        drive,
  input  logic                       sample,
  input  logic [(1<<N_INPUTS)-1:0]   expected,
  output logic                       busy,
  output logic                       done,
  output logic                       table_valid,
  output logic [(1<<N_INPUTS)-1:0]   truth_table,
  output logic                       match
);

  localparam int TW    = table_width(N_INPUTS);
  localparam int IDX_W = N_INPUTS + 1;

  // One extra index bit keeps the terminal compare free of wrap-around.
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(TW - 1);
  localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
  localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE_CYCLES);

  scan_state_t          r_state;
  logic [IDX_W-1:0]     r_index;
  logic [N_INPUTS-1:0]  r_drive;
  logic [TW-1:0]        r_table;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_valid;
  logic                 r_match;

  logic                 w_start_ok;
  logic                 w_settle_zero;
  logic                 w_settle_load;
  logic                 w_settle_dec;
  logic [IDX_W-1:0]     w_index_next;

  assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
  assign w_index_next = r_index + IDX_ONE;

  // Reload on scan start and on every capture edge in HOLD; reloading after
  // the final capture is harmless because the counter is idle outside HOLD.
  assign w_settle_load = w_start_ok || ((r_state == S_HOLD) && w_settle_zero);
  assign w_settle_dec  = (r_state == S_HOLD);

  scan_settle_counter #(
    .WIDTH (SETTLE_W)
  ) u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_settle_load),
    .i_load_val (SETTLE_LOAD),
    .i_dec      (w_settle_dec),
    .o_zero     (w_settle_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_drive <= '0;
      r_table <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_HOLD;
            r_index <= '0;
            r_drive <= '0;
            r_table <= '0;
            r_busy  <= 1'b1;
            r_valid <= 1'b0;
            r_match <= 1'b0;
          end
        end

        S_HOLD: begin
          if (abort) begin
            // Partial table is kept for debug but stays invalid.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_drive <= '0;
            r_index <= '0;
          end else if (w_settle_zero) begin
            r_table[r_index[N_INPUTS-1:0]] <= sample;
            if (r_index == IDX_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_drive <= '0;
            end else begin
              r_index <= w_index_next;
              r_drive <= w_index_next[N_INPUTS-1:0];
            end
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_index <= '0;
          r_valid <= 1'b1;
          r_match <= (r_table == expected);
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign drive       = r_drive;
  assign busy        = r_busy;
  assign done        = r_done;
  assign table_valid = r_valid;
  assign truth_table = r_table;
  assign match       = r_match;

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential characterizer that recovers the truth table of an N-input, single-output combinational logic block. It sweeps every input combination in ascending order onto the block's inputs, waits a programmable settle time, samples the block's output and packs the results into a 2^N-bit truth-table word. It sits beside synthesized case-statement logic modules as a self-check harness: it drives their inputs, reads their output, and compares the recovered table against an expected word.

## Interface
Parameters:
- N_INPUTS, 4, number of inputs of the characterized block (1..8)
- SETTLE_CYCLES, 2, extra cycles each combination is held before sampling (0..255)

Ports:
- clk  input  1  single clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request to begin a scan
- abort  input  1  cancel a scan in progress
- drive  output  N_INPUTS  stimulus to the characterized block; MSB drives inp1, LSB drives inpN
- sample  input  1  output of the characterized block
- expected  input  2^N_INPUTS  reference truth table, sampled when the scan completes
- busy  output  1  high while scanning
- done  output  1  one-cycle pulse when a scan completes
- table_valid  output  1  high while table holds a complete result
- truth_table  output  2^N_INPUTS  bit i = sample captured while drive == i
- match  output  1  truth_table == expected; meaningful only while table_valid

## Operation
- States: IDLE, HOLD, DONE.
- IDLE: drive = 0, busy = 0. On start, go to HOLD, clear truth_table and table_valid, set index = 0, load settle count = SETTLE_CYCLES.
- HOLD: drive = index.
  - While settle count > 0, decrement it each cycle.
  - When the count is 0, capture sample into truth_table[index] on that edge.
    - If index == 2^N−1, go to DONE.
    - Otherwise increment index and reload the count.
- DONE: lasts one cycle. done = 1. Set table_valid and register match = (truth_table == expected) at the end of the cycle. Return to IDLE.
- start while busy: ignored.
- start in IDLE while table_valid = 1: clears table_valid and starts a new scan.
- abort in HOLD: return to IDLE next cycle. drive = 0, table_valid stays 0, no done pulse, and the partial truth_table is retained but invalid.
- abort and start in the same cycle in IDLE: abort wins; no scan starts.
- abort in DONE or IDLE: no effect.
- Index counter is N_INPUTS+1 bits wide so the terminal compare never wraps.

## Timing
- Reset values: drive = 0, busy = 0, done = 0, table_valid = 0, match = 0, truth_table = 0, state IDLE.
- Each combination is driven for exactly SETTLE_CYCLES+1 cycles. The capture uses the sample value present in the last of those cycles.
- start is accepted at edge T0. busy = 1 and drive = 0 from T0+1. Scan length is 2^N·(SETTLE_CYCLES+1) cycles. done is high in the cycle after the last capture. table_valid and match are high from the following edge onward.
- Default parameters: start at T0 gives done high in cycle T0+49 and table_valid at T0+50.
- drive changes only on the capture edge. It is glitch-free registered output.
- rst_n asserted mid-scan: all outputs go to reset values immediately, asynchronously.

## Structure
- Package truth_table_scanner_pkg holds:
  - state enum (IDLE, HOLD, DONE)
  - localparam function table width = 1 << N_INPUTS
  - max settle width constant (8 bits)
- One sub-module, scan_settle_counter: loadable down-counter with a zero flag, parameterized by SETTLE_CYCLES width.
- The FSM, index register and table shift/packing stay in the top module.

## Test plan
- Bench DUT is a 4-input function with minterms 8, 11, 13, 14. start with defaults → done at T0+49, truth_table = 16'h6900. With expected = 16'h6900, match = 1.
- Same DUT, expected = 16'h6901 → table_valid = 1, match = 0, truth_table = 16'h6900.
- SETTLE_CYCLES = 0 with sample = XOR of drive bits → scan takes 16 cycles, truth_table = 16'h6996.
- abort asserted 10 cycles into a scan → busy low next cycle, drive = 0, no done, table_valid = 0. A following start completes normally with the correct table.
- rst_n pulsed low mid-scan → all outputs zero asynchronously. start pressed again while busy is ignored: scan length unchanged, single done pulse.
- N_INPUTS = 1 with inverter DUT → truth_table = 2'b01 after 2·(SETTLE_CYCLES+1) cycles.
